select_encode_seq: RTL and testbench
====================================

# select_encode_seq

Parametrised, sequenced successor to the datapath's register select/encode logic. It latches the instruction word, extracts the Ra/Rb/Rc fields at configurable bit positions, and drives one-hot read and write enables for a register file of NUM_REGS entries. It supports two modes: manual (control-unit strobes, as before) and an automatic operand sequencer that reads up to two source registers and then writes back to Ra after a handshake. It sits between the control unit and the register file.

## Interface

- DATA_W, 32, IR width
- REG_ADDR_W, 4, register field width; NUM_REGS = 2**REG_ADDR_W
- RA_LSB, 23, LSB of Ra field
- RB_LSB, 19, LSB of Rb field
- RC_LSB, 15, LSB of Rc field

Ports:
- in_clk  in  1  sole clock, rising edge
- in_rst_n  in  1  reset, asynchronous, active-low
- in_ir_load  in  1  latch in_ir into internal IR (honoured only in IDLE)
- in_ir  in  DATA_W  instruction word
- in_gra / in_grb / in_grc  in  1 each  manual field selects
- in_read / in_write  in  1 each  manual regfile read/write strobes
- in_base_addr_write  in  1  manual write, same effect as in_write
- in_base_addr_read  in  1  base-address read: R0 reads as zero
- in_start  in  1  start sequencer (IDLE only)
- in_src_cnt  in  2  source operands to read: 0, 1 (Rb), 2 (Rb then Rc); 3 treated as 2
- in_wb_en  in  1  sequence ends with write-back to Ra
- in_wb_valid  in  1  result ready for write-back
- in_abort  in  1  synchronous abort to IDLE
- out_regfile_location  out  REG_ADDR_W  encoded register number
- out_read_onehot  out  NUM_REGS  read enable, at most one bit set
- out_write_onehot  out  NUM_REGS  write enable, at most one bit set
- out_r0_zero  out  1  operand bus must be forced to 0
- out_busy  out  1  sequencer not in IDLE
- out_done  out  1  one-cycle pulse at sequence completion

## Operation

- **IR and fields.** The IR register captures in_ir on in_ir_load in IDLE; the load is ignored otherwise. Ra = ir[RA_LSB+:REG_ADDR_W], and likewise for Rb and Rc.
- **States:** IDLE, SRC_B, SRC_C, WAIT_WB, WRITE.
- **IDLE (manual mode).**
  - location = OR of the fields gated by gra/grb/grc. Overlapping selects OR bitwise, as before.
  - out_read_onehot = decode(location) when in_read.
  - out_write_onehot = decode(location) when in_write | in_base_addr_write.
- **Base-address read.** If in_base_addr_read and location==0 in a read: out_read_onehot=0 and out_r0_zero=1.
- **in_start in IDLE.** Captures src_cnt, wb_en and base_addr_read flags. Next state:
  - SRC_B if src_cnt≥1.
  - else WAIT_WB if wb_en.
  - else done pulse and stay in IDLE.
  - Manual strobes are ignored while busy.
- **SRC_B.** Reads Rb for one cycle. Next: SRC_C if src_cnt≥2, else WAIT_WB if wb_en, else IDLE with out_done.
- **SRC_C.** Reads Rc for one cycle. Next: WAIT_WB if wb_en, else IDLE with out_done.
- **WAIT_WB.** No enables asserted. Holds indefinitely until in_wb_valid, then WRITE.
- **WRITE.** out_write_onehot = decode(Ra) and location = Ra for one cycle; then IDLE with out_done.
- **R0 rule in the sequencer.** The R0-zero rule applies in SRC_B and SRC_C using the captured base_addr_read flag. It never applies to writes.
- **in_abort.** Forces IDLE from any state next cycle, with no out_done. It has priority over in_wb_valid and in_start.
- **Reset.** All outputs are 0, state is IDLE, IR is 0. Reset mid-sequence discards the sequence.

## Timing

- All outputs are registered: they reflect state and inputs sampled at the previous rising edge.
- **Manual mode.** A strobe sampled at edge k gives the enable during cycle k+1, i.e. 1-cycle latency.
- **Sequencer.**
  - in_start sampled at edge k: SRC_B during k+1, SRC_C during k+2.
  - in_wb_valid sampled at edge m in WAIT_WB: WRITE during m+1.
  - out_done is high during the cycle after the last active state (IDLE entry), for exactly one cycle.
  - For src_cnt=0 with wb_en=0, out_done is high during k+1.
- in_start while busy is ignored, with no queueing.
- in_ir_load in the same cycle as in_start in IDLE: the new IR is loaded, and the sequence uses the new IR.
- in_wb_valid outside WAIT_WB is ignored.
- out_read_onehot and out_write_onehot are never simultaneously nonzero.

## Test plan

- **Reset.** Assert in_rst_n=0 mid-SRC_C -> all outputs 0 immediately, IDLE after release, no out_done.
- **Manual mode.** IR=0x029C8000 (Ra=5, Rb=3, Rc=9); gra+read -> location=5, read_onehot=0x0020; grc+base_addr_write -> write_onehot=0x0200.
- **Full sequence.** Same IR; start with src_cnt=2, wb_en=1:
  - read 0x0008 at k+1, 0x0200 at k+2;
  - busy held while wb_valid is withheld for 5 cycles;
  - then write 0x0020 for one cycle, then done pulse.
- **R0 zero.** IR with Rb=0; start with src_cnt=1, base_addr_read=1, wb_en=0 -> read_onehot=0, r0_zero=1 at k+1, done at k+2.
- **Abort and ignored start.** Abort in WAIT_WB -> IDLE next cycle, no write, no done; in_start while busy -> no effect on sequence.
- **Parameter sweep.** REG_ADDR_W=5, NUM_REGS=32, RA_LSB=27 -> Ra=31 gives write_onehot bit 31 only.

Source files
------------

// File: rtl/select_encode_seq.sv
// ---------------------------------------------------------------------------
// select_encode_seq
//
// Register select/encode block with an operand sequencer. Latches the
// instruction word, extracts the Ra/Rb/Rc register fields and drives one-hot
// read/write enables for a register file of NUM_REGS entries.
//
// Two modes of operation:
//   - Manual (IDLE): the control unit selects fields with in_gra/grb/grc and
//     strobes in_read / in_write / in_base_addr_write.
//   - Sequenced: in_start reads up to two sources (Rb, then Rc) and can then
//     wait for a result handshake and write it back to Ra.
//
// Every output is registered. The values presented during a cycle are
// computed from the state and inputs sampled at the preceding rising edge.
//
// Ports:
//   in_clk               clock, rising edge
//   in_rst_n             asynchronous active-low reset
//   in_ir_load, in_ir    instruction word capture (IDLE only)
//   in_gra/grb/grc       manual field selects (ORed together)
//   in_read, in_write    manual register file strobes
//   in_base_addr_write   manual write, same effect as in_write
//   in_base_addr_read    R0 reads as zero (out_r0_zero instead of an enable)
//   in_start             start the sequencer (IDLE only)
//   in_src_cnt           number of source reads: 0, 1 (Rb), 2 or 3 (Rb, Rc)
//   in_wb_en             sequence finishes with a write-back to Ra
//   in_wb_valid          write-back data is ready
//   in_abort             return to IDLE without a done pulse
//   out_regfile_location encoded register number
//   out_read_onehot      one-hot read enable
//   out_write_onehot     one-hot write enable
//   out_r0_zero          operand bus must be forced to zero
//   out_busy             sequencer is active
//   out_done             one-cycle pulse when a sequence completes
// ---------------------------------------------------------------------------
module select_encode_seq #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int RA_LSB     = 23,
    parameter int RB_LSB     = 19,
    parameter int RC_LSB     = 15,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_ir_load,
    input  logic [DATA_W-1:0]     in_ir,
    input  logic                  in_gra,
    input  logic                  in_grb,
    input  logic                  in_grc,
    input  logic                  in_read,
    input  logic                  in_write,
    input  logic                  in_base_addr_write,
    input  logic                  in_base_addr_read,
    input  logic                  in_start,
    input  logic [1:0]            in_src_cnt,
    input  logic                  in_wb_en,
    input  logic                  in_wb_valid,
    input  logic                  in_abort,
    output logic [REG_ADDR_W-1:0] out_regfile_location,
    output logic [NUM_REGS-1:0]   out_read_onehot,
    output logic [NUM_REGS-1:0]   out_write_onehot,
    output logic                  out_r0_zero,
    output logic                  out_busy,
    output logic                  out_done
);

    typedef enum logic [2:0] {
        IDLE,
        SRC_B,
        SRC_C,
        WAIT_WB,
        WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       ir_q, ir_d;
    logic [1:0]              srcCnt_q, srcCnt_d;
    logic                    wbEn_q, wbEn_d;
    logic                    baseRead_q, baseRead_d;

    logic [REG_ADDR_W-1:0]   location_q, location_d;
    logic [NUM_REGS-1:0]     readOneHot_q, readOneHot_d;
    logic [NUM_REGS-1:0]     writeOneHot_q, writeOneHot_d;
    logic                    r0Zero_q, r0Zero_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    seqFinish;
    logic                    manualActive;
    logic [REG_ADDR_W-1:0]   raField, rbField, rcField;
    logic [REG_ADDR_W-1:0]   manualLoc;
    logic                    unusedIrBits;

    function automatic logic [NUM_REGS-1:0] decode(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

    // Fields come from the IR value that will be held next cycle, so a load
    // in the same cycle as in_start is already visible to the sequence.
    assign raField = ir_d[RA_LSB +: REG_ADDR_W];
    assign rbField = ir_d[RB_LSB +: REG_ADDR_W];
    assign rcField = ir_d[RC_LSB +: REG_ADDR_W];

    // Overlapping selects OR their fields bitwise.
    assign manualLoc = ({REG_ADDR_W{in_gra}} & raField)
                     | ({REG_ADDR_W{in_grb}} & rbField)
                     | ({REG_ADDR_W{in_grc}} & rcField);

    // Manual strobes only count in IDLE when the cycle is not claimed by a
    // start or an abort.
    assign manualActive = (state_q == IDLE) && !in_start && !in_abort;

    // IR bits outside the three fields are held but never decoded.
    assign unusedIrBits = ^ir_q;

    // Next-state logic and sequence parameter capture. Abort is applied last
    // so it overrides every other transition and suppresses the done pulse.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        srcCnt_d   = srcCnt_q;
        wbEn_d     = wbEn_q;
        baseRead_d = baseRead_q;
        seqFinish  = 1'b0;

        if (state_q == IDLE && in_ir_load) begin
            ir_d = in_ir;
        end

        case (state_q)
            IDLE: begin
                if (!in_abort && in_start) begin
                    srcCnt_d   = in_src_cnt;
                    wbEn_d     = in_wb_en;
                    baseRead_d = in_base_addr_read;
                    if (in_src_cnt != 2'd0) begin
                        state_d = SRC_B;
                    end else if (in_wb_en) begin
                        state_d = WAIT_WB;
                    end else begin
                        seqFinish = 1'b1;
                    end
                end
            end
            SRC_B: begin
                if (srcCnt_q[1]) begin
                    state_d = SRC_C;
                end else if (wbEn_q) begin
                    state_d = WAIT_WB;
                end else begin
                    state_d   = IDLE;
                    seqFinish = 1'b1;
                end
            end
            SRC_C: begin
                if (wbEn_q) begin
                    state_d = WAIT_WB;
                end else begin
                    state_d   = IDLE;
                    seqFinish = 1'b1;
                end
            end
            WAIT_WB: begin
                if (in_wb_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d   = IDLE;
                seqFinish = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_abort) begin
            state_d   = IDLE;
            seqFinish = 1'b0;
        end
    end

    // Output values for the coming cycle, derived from the state being
    // entered. A read takes precedence over a write in manual mode so the
    // two enables can never be active together. The R0 rule turns a read of
    // register 0 into out_r0_zero and never affects writes.
    always_comb begin
        location_d    = '0;
        readOneHot_d  = '0;
        writeOneHot_d = '0;
        r0Zero_d      = 1'b0;
        busy_d        = (state_d != IDLE);
        done_d        = seqFinish;

        case (state_d)
            SRC_B: begin
                location_d = rbField;
                if (baseRead_d && rbField == '0) begin
                    r0Zero_d = 1'b1;
                end else begin
                    readOneHot_d = decode(rbField);
                end
            end
            SRC_C: begin
                location_d = rcField;
                if (baseRead_d && rcField == '0) begin
                    r0Zero_d = 1'b1;
                end else begin
                    readOneHot_d = decode(rcField);
                end
            end
            WRITE: begin
                location_d    = raField;
                writeOneHot_d = decode(raField);
            end
            IDLE: begin
                if (manualActive) begin
                    location_d = manualLoc;
                    if (in_read) begin
                        if (in_base_addr_read && manualLoc == '0) begin
                            r0Zero_d = 1'b1;
                        end else begin
                            readOneHot_d = decode(manualLoc);
                        end
                    end else if (in_write || in_base_addr_write) begin
                        writeOneHot_d = decode(manualLoc);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State, IR, captured sequence parameters and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= IDLE;
            ir_q          <= '0;
            srcCnt_q      <= '0;
            wbEn_q        <= 1'b0;
            baseRead_q    <= 1'b0;
            location_q    <= '0;
            readOneHot_q  <= '0;
            writeOneHot_q <= '0;
            r0Zero_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            srcCnt_q      <= srcCnt_d;
            wbEn_q        <= wbEn_d;
            baseRead_q    <= baseRead_d;
            location_q    <= location_d;
            readOneHot_q  <= readOneHot_d;
            writeOneHot_q <= writeOneHot_d;
            r0Zero_q      <= r0Zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign out_regfile_location = location_q;
    assign out_read_onehot      = readOneHot_q;
    assign out_write_onehot     = writeOneHot_q;
    assign out_r0_zero          = r0Zero_q;
    assign out_busy             = busy_q;
    assign out_done             = done_q;

endmodule

// File: tb/tb_select_encode_seq.sv
// ---------------------------------------------------------------------------
// tb_select_encode_seq
//
// Scoreboard bench for select_encode_seq. Each stimulus cycle pushes the
// outputs expected in the following cycle; a monitor pops and compares them
// just after every rising edge. A second instance with 5-bit register fields
// and Ra at bit 27 covers the wide-register configuration.
// ---------------------------------------------------------------------------
module tb_select_encode_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus bundle for one cycle of the main instance.
    typedef struct packed {
        logic        irLoad;
        logic [31:0] ir;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        read;
        logic        write;
        logic        baWrite;
        logic        baRead;
        logic        start;
        logic [1:0]  srcCnt;
        logic        wbEn;
        logic        wbValid;
        logic        abort;
    } stim_t;

    // Outputs expected during the cycle after a stimulus.
    typedef struct {
        string       name;
        logic [31:0] loc;
        logic [31:0] rd;
        logic [31:0] wr;
        logic        r0;
        logic        busy;
        logic        done;
    } exp_t;

    logic        rst_n;
    logic        irLoad, gra, grb, grc, rd, wr, baWrite, baRead, start, wbEn, wbValid, abort;
    logic [31:0] ir;
    logic [1:0]  srcCnt;
    logic [3:0]  loc;
    logic [15:0] rdOneHot, wrOneHot;
    logic        r0Zero, busy, done;

    logic        d2IrLoad, d2Gra, d2Write, d2Start, d2WbEn, d2WbValid;
    logic [31:0] d2Ir;
    logic [4:0]  d2Loc;
    logic [31:0] d2Rd, d2Wr;
    logic        d2R0, d2Busy, d2Done;

    exp_t expQ[$];
    exp_t monExp;
    int   checks   = 0;
    int   failures = 0;

    select_encode_seq dut (
        .in_clk               (clk),
        .in_rst_n             (rst_n),
        .in_ir_load           (irLoad),
        .in_ir                (ir),
        .in_gra               (gra),
        .in_grb               (grb),
        .in_grc               (grc),
        .in_read              (rd),
        .in_write             (wr),
        .in_base_addr_write   (baWrite),
        .in_base_addr_read    (baRead),
        .in_start             (start),
        .in_src_cnt           (srcCnt),
        .in_wb_en             (wbEn),
        .in_wb_valid          (wbValid),
        .in_abort             (abort),
        .out_regfile_location (loc),
        .out_read_onehot      (rdOneHot),
        .out_write_onehot     (wrOneHot),
        .out_r0_zero          (r0Zero),
        .out_busy             (busy),
        .out_done             (done)
    );

    select_encode_seq #(.REG_ADDR_W(5), .RA_LSB(27)) dutWide (
        .in_clk               (clk),
        .in_rst_n             (rst_n),
        .in_ir_load           (d2IrLoad),
        .in_ir                (d2Ir),
        .in_gra               (d2Gra),
        .in_grb               (1'b0),
        .in_grc               (1'b0),
        .in_read              (1'b0),
        .in_write             (d2Write),
        .in_base_addr_write   (1'b0),
        .in_base_addr_read    (1'b0),
        .in_start             (d2Start),
        .in_src_cnt           (2'd0),
        .in_wb_en             (d2WbEn),
        .in_wb_valid          (d2WbValid),
        .in_abort             (1'b0),
        .out_regfile_location (d2Loc),
        .out_read_onehot      (d2Rd),
        .out_write_onehot     (d2Wr),
        .out_r0_zero          (d2R0),
        .out_busy             (d2Busy),
        .out_done             (d2Done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t ex(input string name, input logic [31:0] l, input logic [31:0] r,
                                input logic [31:0] w, input logic z, input logic b, input logic d);
        exp_t e;
        e.name = name; e.loc = l; e.rd = r; e.wr = w; e.r0 = z; e.busy = b; e.done = d;
        return e;
    endfunction

    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(negedge clk);
        irLoad  = s.irLoad;  ir      = s.ir;
        gra     = s.gra;     grb     = s.grb;    grc    = s.grc;
        rd      = s.read;    wr      = s.write;  baWrite = s.baWrite;
        baRead  = s.baRead;  start   = s.start;  srcCnt = s.srcCnt;
        wbEn    = s.wbEn;    wbValid = s.wbValid; abort = s.abort;
        expQ.push_back(e);
    endtask

    // Compare the oldest expectation just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput({monExp.name, ".loc"},  64'(loc),      64'(monExp.loc));
            checkOutput({monExp.name, ".rd"},   64'(rdOneHot), 64'(monExp.rd));
            checkOutput({monExp.name, ".wr"},   64'(wrOneHot), 64'(monExp.wr));
            checkOutput({monExp.name, ".r0"},   64'(r0Zero),   64'(monExp.r0));
            checkOutput({monExp.name, ".busy"}, 64'(busy),     64'(monExp.busy));
            checkOutput({monExp.name, ".done"}, 64'(done),     64'(monExp.done));
        end
    end

    initial begin
        stim_t s;
        stim_t idle;
        idle = '0;

        rst_n = 1'b0;
        irLoad = 0; ir = '0; gra = 0; grb = 0; grc = 0; rd = 0; wr = 0; baWrite = 0;
        baRead = 0; start = 0; srcCnt = '0; wbEn = 0; wbValid = 0; abort = 0;
        d2IrLoad = 0; d2Ir = '0; d2Gra = 0; d2Write = 0; d2Start = 0; d2WbEn = 0; d2WbValid = 0;

        #1;
        checkOutput("reset.outputs", {loc, rdOneHot, wrOneHot, r0Zero, busy, done}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Manual mode with IR 0x029C8000: Ra=5, Rb=3, Rc=9.
        s = idle; s.irLoad = 1; s.ir = 32'h029C8000;
        applyStimulus(s, ex("loadIr", 0, 0, 0, 0, 0, 0));
        s = idle; s.gra = 1; s.read = 1;
        applyStimulus(s, ex("manGraRead", 5, 32'h0020, 0, 0, 0, 0));
        s = idle; s.grc = 1; s.baWrite = 1;
        applyStimulus(s, ex("manGrcBaWrite", 9, 0, 32'h0200, 0, 0, 0));
        s = idle; s.grb = 1; s.read = 1; s.baRead = 1;
        applyStimulus(s, ex("manGrbBaRead", 3, 32'h0008, 0, 0, 0, 0));
        s = idle; s.gra = 1; s.grb = 1; s.write = 1;
        applyStimulus(s, ex("manOverlap", 7, 0, 32'h0080, 0, 0, 0));
        s = idle; s.read = 1; s.baRead = 1;
        applyStimulus(s, ex("manR0Zero", 0, 0, 0, 1, 0, 0));
        applyStimulus(idle, ex("manIdle", 0, 0, 0, 0, 0, 0));

        // Full sequence: two sources, then write-back after a 5-cycle wait.
        s = idle; s.start = 1; s.srcCnt = 2; s.wbEn = 1; s.gra = 1; s.read = 1;
        applyStimulus(s, ex("seqSrcB", 3, 32'h0008, 0, 0, 1, 0));
        s = idle; s.wbValid = 1;
        applyStimulus(s, ex("seqSrcC", 9, 32'h0200, 0, 0, 1, 0));
        for (int i = 0; i < 5; i++) begin
            s = idle;
            if (i == 1) begin s.start = 1; s.srcCnt = 1; end
            if (i == 3) begin s.gra = 1; s.write = 1; end
            applyStimulus(s, ex($sformatf("seqWait%0d", i), 0, 0, 0, 0, 1, 0));
        end
        s = idle; s.wbValid = 1;
        applyStimulus(s, ex("seqWrite", 5, 0, 32'h0020, 0, 1, 0));
        applyStimulus(idle, ex("seqDone", 0, 0, 0, 0, 0, 1));
        applyStimulus(idle, ex("seqAfter", 0, 0, 0, 0, 0, 0));

        // R0 rule in the sequencer, with the IR loaded alongside the start.
        s = idle; s.irLoad = 1; s.ir = 32'h02848000; s.start = 1; s.srcCnt = 1; s.baRead = 1;
        applyStimulus(s, ex("r0SrcB", 0, 0, 0, 1, 1, 0));
        applyStimulus(idle, ex("r0Done", 0, 0, 0, 0, 0, 1));
        applyStimulus(idle, ex("r0After", 0, 0, 0, 0, 0, 0));

        // Empty sequence completes immediately.
        s = idle; s.start = 1;
        applyStimulus(s, ex("emptyDone", 0, 0, 0, 0, 0, 1));
        applyStimulus(idle, ex("emptyAfter", 0, 0, 0, 0, 0, 0));

        // src_cnt=3 behaves as 2; without base-address read R0 is enabled.
        s = idle; s.start = 1; s.srcCnt = 3;
        applyStimulus(s, ex("cnt3SrcB", 0, 32'h0001, 0, 0, 1, 0));
        applyStimulus(idle, ex("cnt3SrcC", 9, 32'h0200, 0, 0, 1, 0));
        applyStimulus(idle, ex("cnt3Done", 0, 0, 0, 0, 0, 1));

        // Abort while waiting for write-back, with wb_valid in the same cycle.
        s = idle; s.start = 1; s.wbEn = 1;
        applyStimulus(s, ex("abortWait0", 0, 0, 0, 0, 1, 0));
        applyStimulus(idle, ex("abortWait1", 0, 0, 0, 0, 1, 0));
        s = idle; s.abort = 1; s.wbValid = 1;
        applyStimulus(s, ex("abortIdle", 0, 0, 0, 0, 0, 0));
        applyStimulus(idle, ex("abortAfter", 0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of SRC_C.
        s = idle; s.start = 1; s.srcCnt = 2; s.wbEn = 1;
        applyStimulus(s, ex("rstSrcB", 0, 32'h0001, 0, 0, 1, 0));
        applyStimulus(idle, ex("rstSrcC", 9, 32'h0200, 0, 0, 1, 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstAsync.outputs", {loc, rdOneHot, wrOneHot, r0Zero, busy, done}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idle, ex("rstIdle", 0, 0, 0, 0, 0, 0));
        s = idle; s.gra = 1; s.read = 1;
        applyStimulus(s, ex("rstIrCleared", 0, 32'h0001, 0, 0, 0, 0));
        applyStimulus(idle, ex("rstTail", 0, 0, 0, 0, 0, 0));

        // Wide configuration: Ra=31 at bit 27.
        @(negedge clk);
        d2IrLoad = 1; d2Ir = 32'hF8000000;
        @(negedge clk);
        d2IrLoad = 0; d2Gra = 1; d2Write = 1;
        @(posedge clk); #1;
        checkOutput("wideMan.loc", 64'(d2Loc), 64'd31);
        checkOutput("wideMan.wr",  64'(d2Wr),  64'h80000000);
        checkOutput("wideMan.rd",  64'(d2Rd),  64'h0);
        @(negedge clk);
        d2Gra = 0; d2Write = 0; d2Start = 1; d2WbEn = 1;
        @(posedge clk); #1;
        checkOutput("wideWait.busy", 64'(d2Busy), 64'd1);
        checkOutput("wideWait.wr",   64'(d2Wr),   64'h0);
        @(negedge clk);
        d2Start = 0; d2WbEn = 0; d2WbValid = 1;
        @(posedge clk); #1;
        checkOutput("wideWrite.wr",  64'(d2Wr),  64'h80000000);
        checkOutput("wideWrite.loc", 64'(d2Loc), 64'd31);
        @(negedge clk);
        d2WbValid = 0;
        @(posedge clk); #1;
        checkOutput("wideDone.done", 64'(d2Done), 64'd1);
        checkOutput("wideDone.r0",   64'(d2R0),   64'd0);

        @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
